// File: rtl/register_file_sb.sv
// -----------------------------------------------------------------------------
// register_file_sb
//
// Parametrised multi-port register file with a per-register busy scoreboard for
// the MIPS datapath. DEPTH x WIDTH storage, NREAD combinational read ports and
// one synchronous writeback port. Issue reserves a destination register (sets
// its busy bit); writeback clears it. Decode uses rbusy to stall on RAW hazards.
//
// Parameters:
//   WIDTH  data bits per register
//   DEPTH  number of registers (power of two, >= 2)
//   NREAD  number of read ports (1..4)
//   AW     address width, derived from DEPTH
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   write     in   writeback enable
//   wreg      in   writeback register index
//   wd        in   writeback data
//   reserve   in   mark rsv_reg busy
//   rsv_reg   in   register to reserve
//   rreg      in   read indices, port p = rreg[p*AW +: AW]
//   rd        out  read data,    port p = rd[p*WIDTH +: WIDTH]
//   rbusy     out  busy flag of the register each port addresses
//   any_busy  out  OR of all busy bits (registered state only)
//
// Configuration macro:
//   REGFILE_BYPASS_EN  when defined, a writeback to the register a read port
//                      addresses is forwarded to that port in the same cycle,
//                      and the port's busy flag is cleared unless the same
//                      register is re-reserved in that cycle.
// -----------------------------------------------------------------------------
module register_file_sb #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned NREAD = 2,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   write,
    input  logic [AW-1:0]          wreg,
    input  logic [WIDTH-1:0]       wd,
    input  logic                   reserve,
    input  logic [AW-1:0]          rsv_reg,
    input  logic [NREAD*AW-1:0]    rreg,
    output logic [NREAD*WIDTH-1:0] rd,
    output logic [NREAD-1:0]       rbusy,
    output logic                   any_busy
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Write and reserve are ignored while reset is asserted; gating them here
    // also keeps the bypass path quiet during reset.
    logic write_en;
    logic reserve_en;

    assign write_en   = write & ~rst;
    assign reserve_en = reserve & ~rst;

    // Scoreboard next state: writeback clears, reservation sets. The reserve
    // is applied last so a new producer supersedes a completing one.
    always_comb begin
        busy_d = busy_q;
        if (write_en) begin
            busy_d[wreg] = 1'b0;
        end
        if (reserve_en) begin
            busy_d[rsv_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (write_en) begin
                regs_q[wreg] <= wd;
            end
            busy_q <= busy_d;
        end
    end

    assign any_busy = |busy_q;

    for (genvar p = 0; p < int'(NREAD); p++) begin : g_read
        logic [AW-1:0] idx;

        assign idx = rreg[p*AW +: AW];

`ifdef REGFILE_BYPASS_EN
        logic hit;

        assign hit                    = write_en && (wreg == idx);
        assign rd[p*WIDTH +: WIDTH]   = hit ? wd : regs_q[idx];
        // A forwarded value is ready, unless the same register is being
        // re-reserved by a younger producer in this very cycle.
        assign rbusy[p]               = hit ? (reserve_en && (rsv_reg == wreg)) : busy_q[idx];
`else
        assign rd[p*WIDTH +: WIDTH]   = regs_q[idx];
        assign rbusy[p]               = busy_q[idx];
`endif
    end

endmodule
